k12a_sram_ctrl: RTL and testbench
=================================

# k12a_sram_ctrl

Responder end of the K12A CPU memory bus. The CPU state machine issues fetch, load and store requests from its FETCH/LOAD/STORE states. This block accepts each request, sequences an external asynchronous SRAM through setup, strobe and hold phases, and returns a one-cycle acknowledge with read data. It sits between the CPU core and the board SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: strobe length in cycles; legal range 1–15.
- `ADDR_WIDTH`, default 16: bus and SRAM address width.
- `WP_BASE`, default 16'hF000: first write-protected address; only used when write protection is compiled in.

Ports:
- `cpu_clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `mem_req` in 1: request. Held high, with all request fields stable, until `mem_ack`.
- `mem_we` in 1: 1 = write, 0 = read.
- `mem_addr` in ADDR_WIDTH: request address.
- `mem_wdata` in 8: write data.
- `mem_ack` out 1: one-cycle completion pulse.
- `mem_rdata` out 8: read data. Valid while `mem_ack` is high; holds its value until the next read completes.
- `sram_addr` out ADDR_WIDTH: SRAM address pins.
- `sram_dout` out 8: data driven to the SRAM.
- `sram_dout_oe` out 1: data-bus tristate enable.
- `sram_din` in 8: data bus as read back from the SRAM.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: active-low SRAM strobes.
- `wp_violation` out 1: sticky write-protect flag.

## Operation
- The FSM has five states: IDLE, SETUP, STROBE, HOLD, ACK.
- IDLE:
  - Moves to SETUP when `mem_req` = 1.
  - On that transition, latches `mem_addr` into `sram_addr`, and latches `mem_we` and `mem_wdata` internally.
- SETUP, one cycle:
  - `sram_ce_n` = 0.
  - On a write, `sram_dout_oe` = 1 and `sram_dout` carries the latched data.
  - Moves to STROBE and loads the wait counter with WAIT_CYCLES−1.
- STROBE, WAIT_CYCLES cycles:
  - Read: `sram_oe_n` = 0. Write: `sram_we_n` = 0.
  - The counter decrements each cycle. At 0 the state moves to HOLD.
  - On a read, `sram_din` is captured into `mem_rdata` on that same last-strobe edge.
- HOLD, one cycle:
  - `sram_ce_n` stays 0. `sram_oe_n` and `sram_we_n` return to 1.
  - On a write, `sram_dout_oe` stays 1 so the data is held past the strobe.
- ACK, one cycle:
  - `mem_ack` = 1 and `sram_ce_n` = 1.
  - Always returns to IDLE.
  - `mem_req` is not sampled in the ACK state.
- In IDLE all strobes are 1 and `sram_dout_oe` = 0.
- `sram_addr` holds its last value between accesses.
- The counter is 4 bits wide. It never wraps because it only decrements while nonzero.
- Reset values, all forced on the cycle after `reset` is sampled high:
  - state IDLE; `mem_ack` 0; `mem_rdata` 0; `sram_addr` 0; `sram_dout` 0; `sram_dout_oe` 0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` all 1; `wp_violation` 0.
- Reset in any state aborts the access immediately:
  - All strobes are deasserted at the next edge.
  - No `mem_ack` is issued. `mem_rdata` is cleared.
- `reset` has priority over `mem_req` when both are high.

## Timing
- Numbering: cycle n is the one where IDLE samples `mem_req` = 1.
  - SETUP: n+1.
  - STROBE: n+2 … n+1+W, where W = WAIT_CYCLES.
  - HOLD: n+2+W.
  - `mem_ack` high: n+3+W.
  - Total latency is W+3 cycles after request acceptance.
- Back-to-back requests:
  - After `mem_ack`, the requester may keep `mem_req` high with new fields.
  - IDLE accepts it in cycle n+4+W.
  - The earliest next acceptance is therefore exactly one cycle after the ack cycle, giving a throughput of one access per W+4 cycles.
- Every SRAM output is a flop output, so the block has no combinational path from `mem_*` to `sram_*`.

## Configuration
- Macro: `K12A_SRAM_WRITE_PROTECT_EN`.
- Defined:
  - Applies to a write with latched address ≥ WP_BASE.
  - Runs the full FSM timing and acks normally.
  - `sram_we_n` stays 1 for the whole access and `sram_dout_oe` stays 0.
  - `wp_violation` sets on the SETUP edge and stays set until `reset`.
  - Reads are never blocked.
- Not defined:
  - All writes proceed normally.
  - `wp_violation` is tied to 0. The port is always present.

## Structure
- The shared K12A include gets the `sram_state_t` enum (IDLE, SETUP, STROBE, HOLD, ACK) and the default WAIT_CYCLES constant. These sit alongside the existing CPU `state_t`.
- One sub-module, `k12a_sram_wait_counter`:
  - Ports: load, load value, decrement enable, zero flag.
  - Reset is synchronous, to 0.
- The FSM, data latches and strobe flops live in the top module.

## Test plan
All scenarios use WAIT_CYCLES = 2.
- Read: request at 0x1234 with `sram_din` = 0xA5 → `sram_addr` = 0x1234 from n+1; `sram_oe_n` low at n+2..n+3; `mem_ack` a single pulse at n+5 with `mem_rdata` = 0xA5.
- Write 0x3C to 0x0100 → `sram_we_n` low at n+2..n+3; `sram_dout_oe` high at n+1..n+4 with `sram_dout` = 0x3C; ack at n+5.
- Back-to-back: read then write with `mem_req` held high → second acceptance at n+6, second ack at n+11, no glitch on the strobes in between.
- Reset asserted at n+3, mid-STROBE → at n+4 all strobes are 1, `sram_dout_oe` = 0, no ack is ever issued, `mem_rdata` = 0.
- With the macro defined: write to 0xF010 → `sram_we_n` stays 1 throughout, ack at n+5, `wp_violation` = 1 from n+2; a following write to 0x0010 strobes normally; `wp_violation` is cleared only by `reset`.
- WAIT_CYCLES = 1 (separate build): read → ack at n+4; `sram_oe_n` low for exactly one cycle (n+2).

Source files
------------

// File: rtl/k12a_sram_ctrl_pkg.sv
// Shared K12A definitions: CPU sequencer states and SRAM responder states and constants.
package k12a_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    CPU_FETCH,
    CPU_EXECUTE,
    CPU_LOAD,
    CPU_STORE
  } state_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK
  } sram_state_t;

  localparam int SRAM_WAIT_CYCLES_DEFAULT = 2;
  localparam int SRAM_CNT_WIDTH           = 4;

endpackage

// File: rtl/k12a_sram_wait_counter.sv
// Strobe-length down-counter: loads, then decrements only while nonzero; zero flag is combinational.
// Latency: load/decrement take effect at the next edge; no backpressure.
module k12a_sram_wait_counter
  import k12a_sram_ctrl_pkg::*;
(
  input  logic                      cpu_clock,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic [SRAM_CNT_WIDTH-1:0] i_load_val,
  input  logic                      i_dec,
  output logic                      o_zero
);

  logic [SRAM_CNT_WIDTH-1:0] r_count;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/k12a_sram_ctrl.sv
// K12A memory-bus responder driving an async SRAM through SETUP/STROBE/HOLD; ack WAIT_CYCLES+3 after accept,
// requester holds mem_req until ack. Optional write protection above WP_BASE via K12A_SRAM_WRITE_PROTECT_EN.
module k12a_sram_ctrl
  import k12a_sram_ctrl_pkg::*;
#(
  parameter int                    WAIT_CYCLES = SRAM_WAIT_CYCLES_DEFAULT,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] WP_BASE     = 'hF000
) (
  input  logic                  cpu_clock,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_wdata,
  output logic                  mem_ack,
  output logic [7:0]            mem_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_dout,
  output logic                  sram_dout_oe,
  input  logic [7:0]            sram_din,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  wp_violation
);

`ifdef K12A_SRAM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [SRAM_CNT_WIDTH-1:0] LOAD_VAL = SRAM_CNT_WIDTH'(WAIT_CYCLES - 1);

  sram_state_t r_state;
  logic        r_read;
  logic        r_write;
  logic        r_wp_hit;
  logic        r_wp_violation;
  logic        w_zero;
  logic        w_wp_hit;

  // Decided at acceptance so the SETUP-cycle output enable is already correct.
  assign w_wp_hit     = WP_EN && mem_we && (mem_addr >= WP_BASE);
  assign wp_violation = r_wp_violation;

  k12a_sram_wait_counter u_wait (
    .cpu_clock  (cpu_clock),
    .reset      (reset),
    .i_load     (r_state == SETUP),
    .i_load_val (LOAD_VAL),
    .i_dec      (r_state == STROBE),
    .o_zero     (w_zero)
  );

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_wp_hit       <= 1'b0;
      r_wp_violation <= 1'b0;
      mem_ack        <= 1'b0;
      mem_rdata      <= '0;
      sram_addr      <= '0;
      sram_dout      <= '0;
      sram_dout_oe   <= 1'b0;
      sram_ce_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_we_n      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_state      <= SETUP;
            sram_addr    <= mem_addr;
            sram_dout    <= mem_wdata;
            r_read       <= !mem_we;
            r_write      <= mem_we && !w_wp_hit;
            r_wp_hit     <= w_wp_hit;
            sram_ce_n    <= 1'b0;
            sram_dout_oe <= mem_we && !w_wp_hit;
          end
        end
        SETUP: begin
          r_state   <= STROBE;
          sram_oe_n <= !r_read;
          sram_we_n <= !r_write;
          if (r_wp_hit) begin
            r_wp_violation <= 1'b1;
          end
        end
        STROBE: begin
          if (w_zero) begin
            r_state   <= HOLD;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (r_read) begin
              mem_rdata <= sram_din;
            end
          end
        end
        HOLD: begin
          r_state      <= ACK;
          mem_ack      <= 1'b1;
          sram_ce_n    <= 1'b1;
          sram_dout_oe <= 1'b0;
        end
        ACK: begin
          r_state <= IDLE;
          mem_ack <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_sram_ctrl.sv
// Bench for k12a_sram_ctrl: timeline reference model checked every cycle plus directed literal checks.
module tb_k12a_sram_ctrl;

  localparam int          W       = 2;
  localparam logic [15:0] WP_BASE = 16'hF000;
`ifdef K12A_SRAM_WRITE_PROTECT_EN
  localparam bit WPEN = 1'b1;
`else
  localparam bit WPEN = 1'b0;
`endif

  logic        cpu_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        mem_req   = 1'b0;
  logic        mem_we    = 1'b0;
  logic [15:0] mem_addr  = '0;
  logic [7:0]  mem_wdata = '0;
  logic [7:0]  sram_din  = '0;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_dout_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        wp_violation;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic       din_fixed = 1'b0;
  logic [7:0] din_val   = '0;

  k12a_sram_ctrl #(
    .WAIT_CYCLES (W),
    .ADDR_WIDTH  (16),
    .WP_BASE     (WP_BASE)
  ) dut (
    .cpu_clock    (cpu_clock),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_dout_oe (sram_dout_oe),
    .sram_din     (sram_din),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .wp_violation (wp_violation)
  );

  initial forever #5 cpu_clock = ~cpu_clock;

  initial forever begin
    @(posedge cpu_clock);
    cyc++;
  end

  initial forever begin
    @(posedge cpu_clock);
    #1;
    sram_din = din_fixed ? din_val : 8'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: an access accepted in cycle n occupies n+1..n+W+3; each output is a window over k = cycle-n.
  initial begin : model
    bit          m_live, m_act, m_we, m_blk, m_wp, e_wr;
    int          m_n, k;
    logic [15:0] m_addr;
    logic [7:0]  m_wd, m_rd;
    m_live = 0; m_act = 0; m_we = 0; m_blk = 0; m_wp = 0; e_wr = 0;
    m_n = 0; m_addr = '0; m_wd = '0; m_rd = '0;
    forever begin
      @(negedge cpu_clock);
      k = m_act ? (cyc - m_n) : -1;
      if (m_live) begin
        e_wr = m_act && m_we && !m_blk;
        check("ce_n",   sram_ce_n,    !(m_act && k >= 1 && k <= W + 2));
        check("oe_n",   sram_oe_n,    !(m_act && !m_we && k >= 2 && k <= W + 1));
        check("we_n",   sram_we_n,    !(e_wr && k >= 2 && k <= W + 1));
        check("dout_oe", sram_dout_oe, e_wr && k >= 1 && k <= W + 2);
        check("ack",    mem_ack,      m_act && k == W + 3);
        check("addr",   sram_addr,    m_addr);
        check("rdata",  mem_rdata,    m_rd);
        check("wp",     wp_violation, m_wp);
        if (e_wr && k >= 1 && k <= W + 2) check("dout", sram_dout, m_wd);
      end
      if (reset) begin
        m_live = 1; m_act = 0; m_addr = '0; m_rd = '0; m_wp = 0;
      end else if (m_live) begin
        if (m_act) begin
          if (!m_we && k == W + 1) m_rd = sram_din;
          if (m_blk && k == 1) m_wp = 1;
          if (k == W + 3) m_act = 0;
        end else if (mem_req) begin
          m_act = 1; m_n = cyc; m_we = mem_we; m_addr = mem_addr; m_wd = mem_wdata;
          m_blk = WPEN && mem_we && (mem_addr >= WP_BASE);
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge cpu_clock);
      #1;
    end
  endtask

  task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd, input bit keep,
                        output int n, output int ack_at, output int oe_cnt, output int we_cnt,
                        output int doe_cnt);
    bit seen;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    n = cyc; ack_at = -1; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge cpu_clock);
      #1;
      if (sram_oe_n === 1'b0) oe_cnt++;
      if (sram_we_n === 1'b0) we_cnt++;
      if (sram_dout_oe === 1'b1) doe_cnt++;
      if (mem_ack === 1'b1) begin
        seen = 1;
        ack_at = cyc;
      end
    end
    check("ack_seen", {31'b0, seen}, 32'd1);
    @(posedge cpu_clock);
    #1;
    if (!keep) mem_req = 1'b0;
  endtask

  task automatic abort_access(input logic we, input logic [15:0] addr, input int at);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = 8'($urandom);
    idle(at);
    reset = 1'b1;
    @(posedge cpu_clock);
    #1;
    reset = 1'b0;
    mem_req = 1'b0;
  endtask

  initial begin : stim
    int n1, a1, n2, a2, o, w, d, acks;
    logic        r_we;
    logic [15:0] r_a;
    bit          r_keep;
    idle(2);
    reset = 1'b0;
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_ack", mem_ack, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_addr", sram_addr, 0);

    din_fixed = 1'b1; din_val = 8'hA5;
    access(1'b0, 16'h1234, 8'h00, 1'b0, n1, a1, o, w, d);
    check("rd_latency", a1 - n1, 5);
    check("rd_rdata", mem_rdata, 8'hA5);
    check("rd_oe_cycles", o, 2);
    check("rd_addr", sram_addr, 16'h1234);
    din_fixed = 1'b0;
    idle(2);

    access(1'b1, 16'h0100, 8'h3C, 1'b0, n1, a1, o, w, d);
    check("wr_latency", a1 - n1, 5);
    check("wr_we_cycles", w, 2);
    check("wr_doe_cycles", d, 4);
    check("wr_oe_cycles", o, 0);
    check("wr_rdata_held", mem_rdata, 8'hA5);
    idle(1);

    access(1'b0, 16'h0200, 8'h00, 1'b1, n1, a1, o, w, d);
    access(1'b1, 16'h0201, 8'h77, 1'b0, n2, a2, o, w, d);
    check("b2b_accept", n2 - n1, 6);
    check("b2b_ack2", a2 - n1, 11);
    idle(2);

    abort_access(1'b0, 16'h4321, 3);
    check("abort_ce_n", sram_ce_n, 1);
    check("abort_oe_n", sram_oe_n, 1);
    check("abort_doe", sram_dout_oe, 0);
    check("abort_rdata", mem_rdata, 0);
    acks = 0;
    for (int t = 0; t < 10; t++) begin
      idle(1);
      if (mem_ack === 1'b1) acks++;
    end
    check("abort_no_ack", acks, 0);

    access(1'b1, 16'hF010, 8'h5A, 1'b0, n1, a1, o, w, d);
    check("wp_latency", a1 - n1, 5);
    check("wp_we_cycles", w, WPEN ? 0 : 2);
    check("wp_flag", wp_violation, WPEN);
    access(1'b1, 16'h0010, 8'h11, 1'b0, n1, a1, o, w, d);
    check("wp_low_we_cycles", w, 2);
    check("wp_sticky", wp_violation, WPEN);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      r_we = 1'($urandom);
      r_a  = ($urandom_range(0, 3) == 0) ? {4'hF, 12'($urandom)} : 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        abort_access(r_we, r_a, $urandom_range(0, W + 3));
        idle($urandom_range(0, 2));
      end else begin
        r_keep = ($urandom_range(0, 2) == 0);
        access(r_we, r_a, 8'($urandom), r_keep, n1, a1, o, w, d);
        check("rand_latency", a1 - n1, W + 3);
        if (!r_keep) idle($urandom_range(0, 3));
      end
    end
    mem_req = 1'b0;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
